// File: rtl/spi_adc_scanner_if.sv
// -----------------------------------------------------------------------------
// spi_adc_scanner_if
// Result handshake between the ADC scanner and its consumer.
//   out_valid : scanner -> consumer, a conversion result is held
//   out_ready : consumer -> scanner, consumer takes the held result
//   out_data  : scanner -> consumer, conversion result (DATA_W bits)
//   out_ch    : scanner -> consumer, channel that produced out_data
// Modports: master (scanner side), slave (consumer side).
// -----------------------------------------------------------------------------
interface spi_adc_scanner_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_ch;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );
endinterface

// File: rtl/spi_adc_scanner.sv
// -----------------------------------------------------------------------------
// spi_adc_scanner
// SPI mode-3 master that round-robin scans the enabled channels of a serial
// multi-channel ADC and returns each conversion tagged with its channel.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   enable, ch_mask : run continuous scan / per-channel enable (IDLE-sampled)
//   miso            : ADC DOUT
//   mosi, sclk, cs_b: ADC DIN, SPI clock (idles high), chip select (active low)
//   overrun         : sticky flag, a result was dropped while one was pending
//   res             : result handshake (out_valid/out_ready/out_data/out_ch)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_adc_scanner #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 3,
    parameter int ADDR_POS   = 2,
    parameter int NUM_CH     = 8,
    parameter int DIV        = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic                miso,
    output logic                mosi,
    output logic                sclk,
    output logic                cs_b,
    output logic                overrun,
    spi_adc_scanner_if.master   res
);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [DCW-1:0]    DIV_LAST   = DCW'(DIV - 1);
    // The cs_b-high gap between frames is DIV cycles in total: HOLD takes
    // DIV-1 of them and the single IDLE cycle the last one, which keeps the
    // frame period at (2 + 2*FRAME_BITS)*DIV. With DIV=1 HOLD is skipped.
    localparam logic [DCW-1:0]    HOLD_LAST  = DCW'((DIV > 1) ? DIV - 2 : 0);
    localparam logic [BCW-1:0]    BIT_LAST   = BCW'(FRAME_BITS - 1);
    localparam logic [BCW-1:0]    DATA_FIRST = BCW'(FRAME_BITS - DATA_W);
    localparam logic [ADDR_W-1:0] CH_LAST    = ADDR_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state_r, state_n;
    logic [DCW-1:0]      div_cnt_r, div_cnt_n;
    logic [BCW-1:0]      bit_cnt_r, bit_cnt_n;
    logic                phase_r, phase_n;      // 0: sclk low half, 1: high half
    logic [ADDR_W-1:0]   cur_ch_r, cur_ch_n;
    logic [ADDR_W-1:0]   last_ch_r, last_ch_n;
    logic [DATA_W-1:0]   shift_r, shift_n;
    logic                cs_b_r, cs_b_n;
    logic                sclk_r, sclk_n;
    logic                mosi_r, mosi_n;
    logic                out_valid_r, out_valid_n;
    logic [DATA_W-1:0]   out_data_r, out_data_n;
    logic [ADDR_W-1:0]   out_ch_r, out_ch_n;
    logic                overrun_r, overrun_n;
    logic                publish_s;

    // Round-robin pick: first set mask bit after 'last', wrapping around.
    function automatic logic [ADDR_W-1:0] next_channel(
        input logic [NUM_CH-1:0] mask,
        input logic [ADDR_W-1:0] last
    );
        logic [ADDR_W-1:0] pick;
        logic              found;
        logic [NUM_CH-1:0] sh;
        int                idx;
        pick  = {ADDR_W{1'b0}};
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx   = (int'(last) + i) % NUM_CH;
            sh    = mask >> idx;
            pick  = (!found && sh[0]) ? ADDR_W'(idx) : pick;
            found = found | sh[0];
        end
        return pick;
    endfunction

    // MOSI value for frame bit k: channel address MSB-first at ADDR_POS.
    function automatic logic addr_bit(input logic [ADDR_W-1:0] ch, input int k);
        logic [ADDR_W-1:0] shc;
        logic              b;
        shc = ch << (k - ADDR_POS);
        b   = ((k >= ADDR_POS) && (k < ADDR_POS + ADDR_W)) ? shc[ADDR_W-1] : 1'b0;
        return b;
    endfunction

    // Next-state, SPI pin and result-handshake logic.
    always_comb begin
        state_n     = state_r;
        div_cnt_n   = div_cnt_r;
        bit_cnt_n   = bit_cnt_r;
        phase_n     = phase_r;
        cur_ch_n    = cur_ch_r;
        last_ch_n   = last_ch_r;
        shift_n     = shift_r;
        cs_b_n      = cs_b_r;
        sclk_n      = sclk_r;
        mosi_n      = mosi_r;
        out_valid_n = out_valid_r;
        out_data_n  = out_data_r;
        out_ch_n    = out_ch_r;
        overrun_n   = overrun_r;
        publish_s   = 1'b0;

        case (state_r)
            IDLE: begin
                cs_b_n    = 1'b1;
                sclk_n    = 1'b1;
                mosi_n    = 1'b0;
                div_cnt_n = {DCW{1'b0}};
                if (enable && (ch_mask != {NUM_CH{1'b0}})) begin
                    cur_ch_n = next_channel(ch_mask, last_ch_r);
                    cs_b_n   = 1'b0;
                    state_n  = SETUP;
                end else if (!enable) begin
                    overrun_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            SETUP: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_n = {DCW{1'b0}};
                    bit_cnt_n = {BCW{1'b0}};
                    phase_n   = 1'b0;
                    sclk_n    = 1'b0;
                    mosi_n    = addr_bit(cur_ch_r, 0);
                    state_n   = SHIFT;
                end else begin
                    div_cnt_n = div_cnt_r + 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt_r != DIV_LAST) begin
                    div_cnt_n = div_cnt_r + 1'b1;
                end else if (!phase_r) begin
                    // sclk rises on this edge: sample miso for data bits
                    div_cnt_n = {DCW{1'b0}};
                    phase_n   = 1'b1;
                    sclk_n    = 1'b1;
                    if (bit_cnt_r >= DATA_FIRST) begin
                        shift_n = {shift_r[DATA_W-2:0], miso};
                    end else begin
                        shift_n = shift_r;
                    end
                end else if (bit_cnt_r == BIT_LAST) begin
                    div_cnt_n = {DCW{1'b0}};
                    cs_b_n    = 1'b1;
                    sclk_n    = 1'b1;
                    mosi_n    = 1'b0;
                    if (DIV == 1) begin
                        publish_s = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        state_n = HOLD;
                    end
                end else begin
                    // sclk falls on this edge: launch the next mosi bit
                    div_cnt_n = {DCW{1'b0}};
                    bit_cnt_n = bit_cnt_r + 1'b1;
                    phase_n   = 1'b0;
                    sclk_n    = 1'b0;
                    mosi_n    = addr_bit(cur_ch_r, int'(bit_cnt_r) + 1);
                end
            end
            HOLD: begin
                cs_b_n = 1'b1;
                sclk_n = 1'b1;
                mosi_n = 1'b0;
                if (div_cnt_r == HOLD_LAST) begin
                    div_cnt_n = {DCW{1'b0}};
                    publish_s = 1'b1;
                    state_n   = IDLE;
                end else begin
                    div_cnt_n = div_cnt_r + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cs_b_n  = 1'b1;
                sclk_n  = 1'b1;
                mosi_n  = 1'b0;
            end
        endcase

        if (publish_s) begin
            last_ch_n = cur_ch_r;
            if (!out_valid_r || res.out_ready) begin
                out_data_n  = shift_r;
                out_ch_n    = cur_ch_r;
                out_valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end else if (out_valid_r && res.out_ready) begin
            out_valid_n = 1'b0;
        end else begin
            out_valid_n = out_valid_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            div_cnt_r   <= {DCW{1'b0}};
            bit_cnt_r   <= {BCW{1'b0}};
            phase_r     <= 1'b0;
            cur_ch_r    <= {ADDR_W{1'b0}};
            last_ch_r   <= CH_LAST;
            shift_r     <= {DATA_W{1'b0}};
            cs_b_r      <= 1'b1;
            sclk_r      <= 1'b1;
            mosi_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_ch_r    <= {ADDR_W{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            div_cnt_r   <= div_cnt_n;
            bit_cnt_r   <= bit_cnt_n;
            phase_r     <= phase_n;
            cur_ch_r    <= cur_ch_n;
            last_ch_r   <= last_ch_n;
            shift_r     <= shift_n;
            cs_b_r      <= cs_b_n;
            sclk_r      <= sclk_n;
            mosi_r      <= mosi_n;
            out_valid_r <= out_valid_n;
            out_data_r  <= out_data_n;
            out_ch_r    <= out_ch_n;
            overrun_r   <= overrun_n;
        end
    end

    assign cs_b          = cs_b_r;
    assign sclk          = sclk_r;
    assign mosi          = mosi_r;
    assign overrun       = overrun_r;
    assign res.out_valid = out_valid_r;
    assign res.out_data  = out_data_r;
    assign res.out_ch    = out_ch_r;
endmodule

// File: tb/tb_spi_adc_scanner.sv
// -----------------------------------------------------------------------------
// tb_spi_adc_scanner
// Directed bench: DUT A uses default parameters (DIV=4), DUT B uses DIV=1.
// Each has a small ADC model that shifts a fixed 16-bit frame word out on
// sclk falling edges while cs_b is low.
// -----------------------------------------------------------------------------
module tb_spi_adc_scanner;
    localparam logic [15:0] A_WORD = 16'h0A5C;
    localparam logic [15:0] B_WORD = 16'h0FFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // DUT A signals
    logic       a_enable;
    logic [7:0] a_mask;
    logic       a_miso = 1'b0;
    logic       a_mosi, a_sclk, a_cs_b, a_overrun;
    spi_adc_scanner_if #(.DATA_W(12), .ADDR_W(3)) a_if ();

    // DUT B signals
    logic       b_enable;
    logic [7:0] b_mask;
    logic       b_miso = 1'b0;
    logic       b_mosi, b_sclk, b_cs_b, b_overrun;
    spi_adc_scanner_if #(.DATA_W(12), .ADDR_W(3)) b_if ();

    spi_adc_scanner #(.FRAME_BITS(16), .DATA_W(12), .ADDR_W(3), .ADDR_POS(2),
                      .NUM_CH(8), .DIV(4)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable), .ch_mask(a_mask),
        .miso(a_miso), .mosi(a_mosi), .sclk(a_sclk), .cs_b(a_cs_b),
        .overrun(a_overrun), .res(a_if)
    );

    spi_adc_scanner #(.FRAME_BITS(16), .DATA_W(12), .ADDR_W(3), .ADDR_POS(2),
                      .NUM_CH(8), .DIV(1)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable), .ch_mask(b_mask),
        .miso(b_miso), .mosi(b_mosi), .sclk(b_sclk), .cs_b(b_cs_b),
        .overrun(b_overrun), .res(b_if)
    );

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: ADC model, mosi capture, frame timing and valid counting
    logic        a_prev_cs = 1'b1, a_prev_sclk = 1'b1;
    logic [15:0] a_sh = 16'h0, a_mosi_w = 16'h0, a_last_mosi = 16'h0;
    int          a_fall_last = 0, a_fall_prev = 0, a_rises = 0, a_valid_cycles = 0;
    always @(negedge clk) begin
        a_prev_cs   <= a_cs_b;
        a_prev_sclk <= a_sclk;
        if (a_cs_b) begin
            a_sh <= A_WORD;
        end else begin
            if (a_prev_sclk && !a_sclk) begin
                a_miso <= a_sh[15];
                a_sh   <= a_sh << 1;
            end
            if (!a_prev_sclk && a_sclk) a_mosi_w <= {a_mosi_w[14:0], a_mosi};
        end
        if (a_prev_cs && !a_cs_b) begin
            a_fall_prev <= a_fall_last;
            a_fall_last <= cyc;
            a_mosi_w    <= 16'h0;
        end
        if (!a_prev_cs && a_cs_b) begin
            a_last_mosi <= a_mosi_w;
            a_rises     <= a_rises + 1;
        end
        if (a_if.out_valid) a_valid_cycles <= a_valid_cycles + 1;
    end

    // DUT B: ADC model, cs-low length, sclk rise count, period, last result
    logic        b_prev_cs = 1'b1, b_prev_sclk = 1'b1;
    logic [15:0] b_sh = 16'h0;
    int          b_low_cnt = 0, b_rise_cnt = 0, b_cs_low_len = 0, b_sclk_rises = 0;
    int          b_fall_last = 0, b_period = 0;
    logic [11:0] b_last_data = 12'h0;
    logic [2:0]  b_last_ch = 3'h0;
    always @(negedge clk) begin
        b_prev_cs   <= b_cs_b;
        b_prev_sclk <= b_sclk;
        if (b_cs_b) begin
            b_sh       <= B_WORD;
            b_low_cnt  <= 0;
            b_rise_cnt <= 0;
        end else begin
            b_low_cnt <= b_low_cnt + 1;
            if (b_prev_sclk && !b_sclk) begin
                b_miso <= b_sh[15];
                b_sh   <= b_sh << 1;
            end
            if (!b_prev_sclk && b_sclk) b_rise_cnt <= b_rise_cnt + 1;
        end
        if (!b_prev_cs && b_cs_b) begin
            b_cs_low_len <= b_low_cnt;
            b_sclk_rises <= b_rise_cnt;
        end
        if (b_prev_cs && !b_cs_b) begin
            b_fall_last <= cyc;
            b_period    <= cyc - b_fall_last;
        end
        if (b_if.out_valid) begin
            b_last_data <= b_if.out_data;
            b_last_ch   <= b_if.out_ch;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid_a(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (a_if.out_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_cs_low_a(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (!a_cs_b) ok = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        bit ok;
        int v0, r0, lows;

        reset = 1'b1;
        a_enable = 1'b0;  a_mask = 8'h00;  a_if.out_ready = 1'b0;
        b_enable = 1'b0;  b_mask = 8'h01;  b_if.out_ready = 1'b1;
        tick(3);

        // reset values
        check_eq("rst_cs_b",      a_cs_b, 1);
        check_eq("rst_sclk",      a_sclk, 1);
        check_eq("rst_mosi",      a_mosi, 0);
        check_eq("rst_out_valid", a_if.out_valid, 0);
        check_eq("rst_out_data",  a_if.out_data, 0);
        check_eq("rst_out_ch",    a_if.out_ch, 0);
        check_eq("rst_overrun",   a_overrun, 0);
        reset = 1'b0;

        // scan mask 0x05 with a consumer that is always ready
        v0 = a_valid_cycles;
        r0 = a_rises;
        a_if.out_ready = 1'b1;
        a_mask = 8'h05;
        a_enable = 1'b1;
        b_enable = 1'b1;
        wait_valid_a(300, ok);
        check_eq("scan_r0_seen", ok, 1);
        check_eq("scan_r0_ch",   a_if.out_ch, 0);
        check_eq("scan_r0_data", a_if.out_data, 12'hA5C);
        check_eq("scan_r0_mosi", a_last_mosi, 16'h0000);
        tick(1);
        wait_valid_a(300, ok);
        check_eq("scan_r1_seen", ok, 1);
        check_eq("scan_r1_ch",   a_if.out_ch, 2);
        check_eq("scan_r1_data", a_if.out_data, 12'hA5C);
        check_eq("scan_r1_mosi", a_last_mosi, 16'h1000);
        tick(1);
        wait_valid_a(300, ok);
        check_eq("scan_r2_ch",   a_if.out_ch, 0);
        check_eq("frame_period", a_fall_last - a_fall_prev, 136);
        tick(1);
        wait_valid_a(300, ok);
        check_eq("scan_r3_ch",   a_if.out_ch, 2);
        tick(1);
        check_eq("valid_cycles_per_frame", a_valid_cycles - v0, 4);
        check_eq("frames_done",            a_rises - r0, 4);

        // DIV=1 instance has been scanning channel 0 meanwhile
        check_eq("div1_data",       b_last_data, 12'hFFE);
        check_eq("div1_ch",         b_last_ch, 0);
        check_eq("div1_period",     b_period, 34);
        check_eq("div1_cs_low_len", b_cs_low_len, 33);
        check_eq("div1_sclk_rises", b_sclk_rises, 16);

        // overrun: consumer stalled across two frames
        a_if.out_ready = 1'b0;
        pulse_reset();
        wait_valid_a(300, ok);
        check_eq("ovr_first_seen", ok, 1);
        check_eq("ovr_first_ch",   a_if.out_ch, 0);
        check_eq("ovr_first_data", a_if.out_data, 12'hA5C);
        check_eq("ovr_not_yet",    a_overrun, 0);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (a_overrun) ok = 1'b1;
        end
        check_eq("ovr_set",        ok, 1);
        check_eq("ovr_held_ch",    a_if.out_ch, 0);
        check_eq("ovr_held_valid", a_if.out_valid, 1);
        a_enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!a_overrun) ok = 1'b1;
        end
        tick(5);
        check_eq("ovr_cleared",    a_overrun, 0);
        check_eq("ovr_idle_cs_b",  a_cs_b, 1);

        // reset in the middle of SHIFT
        a_mask = 8'h06;
        a_enable = 1'b1;
        pulse_reset();
        wait_valid_a(300, ok);
        check_eq("mid_r0_ch", a_if.out_ch, 1);
        tick(1);
        wait_cs_low_a(50, ok);
        check_eq("mid_frame2_start", ok, 1);
        tick(68);
        check_eq("mid_in_frame", a_cs_b, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_cs_b",  a_cs_b, 1);
        check_eq("mid_rst_sclk",  a_sclk, 1);
        check_eq("mid_rst_valid", a_if.out_valid, 0);
        reset = 1'b0;
        a_if.out_ready = 1'b1;
        wait_valid_a(300, ok);
        check_eq("mid_rescan_ch", a_if.out_ch, 1);

        // mask change mid-frame, then empty mask
        a_mask = 8'h01;
        pulse_reset();
        wait_cs_low_a(50, ok);
        check_eq("mask_frame_start", ok, 1);
        a_mask = 8'h80;
        wait_valid_a(300, ok);
        check_eq("mask_cur_ch", a_if.out_ch, 0);
        tick(1);
        wait_valid_a(300, ok);
        check_eq("mask_next_ch",   a_if.out_ch, 7);
        check_eq("mask_next_data", a_if.out_data, 12'hA5C);
        check_eq("mask_next_mosi", a_last_mosi, 16'h3800);
        a_mask = 8'h00;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!a_cs_b) lows++;
        end
        check_eq("empty_mask_cs_low_cycles", lows, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
